// File: rtl/dp_tap_pkg.sv
// Shared types and constants for the dp_tap_mdr JTAG test access port.
package dp_tap_pkg;

  // IEEE 1149.1 TAP states, using the customary 4-bit state encoding.
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  // Which data register class the current instruction selects.
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  // Instruction codes: USER k is IR_USER_BASE + k, everything unlisted is BYPASS.
  localparam int IR_IDCODE    = 1;
  localparam int IR_USER_BASE = 2;

  // Low bits loaded into the IR shift register in CAP_IR; upper bits are zero.
  localparam logic [1:0] IR_CAP_LSBS = 2'b01;

endpackage

// File: rtl/dp_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller: state register plus next-state logic.
module dp_tap_fsm
  import dp_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state_q,
  output tap_state_t state_d
);

  // State register; trst forces Test-Logic-Reset immediately.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  // Next state from the current state and tms.
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms ? TLR      : RTI;
      RTI:      state_d = tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

endmodule

// File: rtl/dp_tap_mdr.sv
// JTAG TAP with instruction register, BYPASS, IDCODE and N_DR user data
// registers exchanged with the debug core through strobed parallel ports.
module dp_tap_mdr
  import dp_tap_pkg::*;
#(
  parameter int          IR_W   = 4,
  parameter int          DR_W   = 32,
  parameter int          N_DR   = 2,
  parameter logic [31:0] IDCODE = 32'h1BA0_0477
) (
  input  logic                   tck,
  input  logic                   trst,
  input  logic                   tdi,
  input  logic                   tms,
  output logic                   tdo,
  output logic                   tdo_en,
  input  logic [N_DR*DR_W-1:0]   dr_cap_data,
  output logic [N_DR-1:0]        dr_cap_stb,
  output logic [N_DR*DR_W-1:0]   dr_upd_data,
  output logic [N_DR-1:0]        dr_upd_vld,
  output logic [3:0]             tap_state,
  output logic [IR_W-1:0]        ir_q
);

  // Parameter sanity: user codes must fit below the all-ones BYPASS code.
  if (DR_W < 1) begin : g_bad_dr_w
    $error("dp_tap_mdr: DR_W must be at least 1");
  end
  if (N_DR < 1) begin : g_bad_n_dr
    $error("dp_tap_mdr: N_DR must be at least 1");
  end
  if (2 + N_DR > (1 << IR_W) - 1) begin : g_bad_ir_w
    $error("dp_tap_mdr: IR_W too small for 2+N_DR instruction codes");
  end
  if (IDCODE[0] != 1'b1) begin : g_bad_idcode
    $error("dp_tap_mdr: IDCODE bit 0 must be 1");
  end

  tap_state_t                  state_q, state_d;
  logic [IR_W-1:0]             ir_sr_q, ir_sr_d, ir_d;
  logic                        bypass_q, bypass_d;
  logic [31:0]                 id_sr_q, id_sr_d;
  logic [DR_W-1:0]             usr_sr_q, usr_sr_d;
  logic [N_DR-1:0][DR_W-1:0]   cap_arr, upd_q, upd_d;
  logic [N_DR-1:0]             stb_q, stb_d, vld_q, vld_d;
  dr_sel_t                     dr_sel;
  logic [N_DR-1:0]             usr_hit;

  dp_tap_fsm u_fsm (
    .tck     (tck),
    .trst    (trst),
    .tms     (tms),
    .state_q (state_q),
    .state_d (state_d)
  );

  assign cap_arr     = dr_cap_data;
  assign dr_upd_data = upd_q;
  assign dr_cap_stb  = stb_q;
  assign dr_upd_vld  = vld_q;
  assign tap_state   = state_q;

  // Instruction decode: IDCODE, one-hot USER k, otherwise BYPASS.
  always_comb begin
    dr_sel  = DR_BYPASS;
    usr_hit = '0;
    if (ir_q == IR_W'(IR_IDCODE)) dr_sel = DR_IDCODE;
    for (int k = 0; k < N_DR; k++) begin
      if (ir_q == IR_W'(IR_USER_BASE + k)) begin
        dr_sel     = DR_USER;
        usr_hit[k] = 1'b1;
      end
    end
  end

  // IR path: capture pattern, shift right from tdi, update; TLR entry forces IDCODE.
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    case (state_q)
      CAP_IR:   ir_sr_d = IR_W'(IR_CAP_LSBS);
      SHIFT_IR: ir_sr_d = IR_W'({tdi, ir_sr_q} >> 1);
      UPD_IR:   ir_d    = ir_sr_q;
      default:  ;
    endcase
    if (state_d == TLR) ir_d = IR_W'(IR_IDCODE);
  end

  // DR path: capture/shift the selected register; update and pulse for USER k.
  always_comb begin
    bypass_d = bypass_q;
    id_sr_d  = id_sr_q;
    usr_sr_d = usr_sr_q;
    upd_d    = upd_q;
    stb_d    = '0;
    vld_d    = '0;
    case (state_q)
      CAP_DR: begin
        case (dr_sel)
          DR_IDCODE: id_sr_d = IDCODE;
          DR_USER: begin
            for (int k = 0; k < N_DR; k++) begin
              if (usr_hit[k]) usr_sr_d = cap_arr[k];
            end
            stb_d = usr_hit;
          end
          default:   bypass_d = 1'b0;
        endcase
      end
      SHIFT_DR: begin
        case (dr_sel)
          DR_IDCODE: id_sr_d  = {tdi, id_sr_q[31:1]};
          DR_USER:   usr_sr_d = DR_W'({tdi, usr_sr_q} >> 1);
          default:   bypass_d = tdi;
        endcase
      end
      UPD_DR: begin
        for (int k = 0; k < N_DR; k++) begin
          if (usr_hit[k]) upd_d[k] = usr_sr_q;
        end
        vld_d = usr_hit;
      end
      default: ;
    endcase
  end

  // Serial output: LSB of the active shift register, only in the shift states.
  always_comb begin
    tdo    = 1'b0;
    tdo_en = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo    = ir_sr_q[0];
      tdo_en = 1'b1;
    end else if (state_q == SHIFT_DR) begin
      tdo_en = 1'b1;
      case (dr_sel)
        DR_IDCODE: tdo = id_sr_q[0];
        DR_USER:   tdo = usr_sr_q[0];
        default:   tdo = bypass_q;
      endcase
    end
  end

  // Register bank; trst clears everything, including the update values.
  // NOTE: upd_q is a flop array, not RAM, because trst must clear it.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr_q  <= '0;
      ir_q     <= IR_W'(IR_IDCODE);
      bypass_q <= 1'b0;
      id_sr_q  <= '0;
      usr_sr_q <= '0;
      upd_q    <= '0;
      stb_q    <= '0;
      vld_q    <= '0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
      id_sr_q  <= id_sr_d;
      usr_sr_q <= usr_sr_d;
      upd_q    <= upd_d;
      stb_q    <= stb_d;
      vld_q    <= vld_d;
    end
  end

endmodule

// File: tb/tb_dp_tap_mdr.sv
// Self-checking bench for dp_tap_mdr: state-walk table, directed scans and
// random tms/tdi traffic checked against a queue-based reference model.
module tb_dp_tap_mdr;
  import dp_tap_pkg::*;

  localparam int          IR_W   = 4;
  localparam int          DR_W   = 32;
  localparam int          N_DR   = 2;
  localparam logic [31:0] IDCODE = 32'h1BA0_0477;

  logic                 tck = 1'b0;
  logic                 trst, tdi, tms;
  logic                 tdo, tdo_en;
  logic [N_DR*DR_W-1:0] dr_cap_data;
  logic [N_DR-1:0]      dr_cap_stb, dr_upd_vld;
  logic [N_DR*DR_W-1:0] dr_upd_data;
  logic [3:0]           tap_state;
  logic [IR_W-1:0]      ir_q;

  int n_chk  = 0;
  int n_pass = 0;
  int stb_cnt, vld_cnt;

  always #5 tck = ~tck;

  dp_tap_mdr #(
    .IR_W(IR_W), .DR_W(DR_W), .N_DR(N_DR), .IDCODE(IDCODE)
  ) dut (
    .tck         (tck),
    .trst        (trst),
    .tdi         (tdi),
    .tms         (tms),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .dr_cap_data (dr_cap_data),
    .dr_cap_stb  (dr_cap_stb),
    .dr_upd_data (dr_upd_data),
    .dr_upd_vld  (dr_upd_vld),
    .tap_state   (tap_state),
    .ir_q        (ir_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Transition table, active chain as a bit queue (LSB at the front).
  tap_state_t      nxt [16][2];
  tap_state_t      m_state;
  int              m_ir;
  bit              m_ir_ch[$];
  bit              m_dr_ch[$];
  logic [DR_W-1:0] m_upd [N_DR];
  logic [N_DR-1:0] m_stb, m_vld;

  task automatic arc(input tap_state_t s, input tap_state_t n0, input tap_state_t n1);
    nxt[int'(s)][0] = n0;
    nxt[int'(s)][1] = n1;
  endtask

  task automatic build_table();
    arc(TLR, RTI, TLR);           arc(RTI, RTI, SEL_DR);
    arc(SEL_DR, CAP_DR, SEL_IR);  arc(CAP_DR, SHIFT_DR, EXIT1_DR);
    arc(SHIFT_DR, SHIFT_DR, EXIT1_DR); arc(EXIT1_DR, PAUSE_DR, UPD_DR);
    arc(PAUSE_DR, PAUSE_DR, EXIT2_DR); arc(EXIT2_DR, SHIFT_DR, UPD_DR);
    arc(UPD_DR, RTI, SEL_DR);     arc(SEL_IR, CAP_IR, TLR);
    arc(CAP_IR, SHIFT_IR, EXIT1_IR); arc(SHIFT_IR, SHIFT_IR, EXIT1_IR);
    arc(EXIT1_IR, PAUSE_IR, UPD_IR); arc(PAUSE_IR, PAUSE_IR, EXIT2_IR);
    arc(EXIT2_IR, SHIFT_IR, UPD_IR); arc(UPD_IR, RTI, SEL_DR);
  endtask

  function automatic logic [63:0] chain_val(input bit ch[$]);
    logic [63:0] v = '0;
    foreach (ch[i]) v[i] = ch[i];
    return v;
  endfunction

  function automatic int user_of(input int ir);
    if (ir >= IR_USER_BASE && ir < IR_USER_BASE + N_DR) return ir - IR_USER_BASE;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = TLR;
    m_ir    = 1;
    m_ir_ch = {};
    for (int i = 0; i < IR_W; i++) m_ir_ch.push_back(1'b0);
    m_dr_ch = {1'b0};
    for (int k = 0; k < N_DR; k++) m_upd[k] = '0;
    m_stb = '0;
    m_vld = '0;
  endtask

  task automatic model_edge(input bit t_ms, input bit t_di);
    tap_state_t  nx = nxt[int'(m_state)][t_ms];
    int          u  = user_of(m_ir);
    logic [63:0] v;
    int          len;
    m_stb = '0;
    m_vld = '0;
    case (m_state)
      CAP_IR: begin
        m_ir_ch = {};
        for (int i = 0; i < IR_W; i++) m_ir_ch.push_back(i == 0);
      end
      SHIFT_IR: begin
        void'(m_ir_ch.pop_front());
        m_ir_ch.push_back(t_di);
      end
      UPD_IR: m_ir = int'(chain_val(m_ir_ch));
      CAP_DR: begin
        if (m_ir == 1) begin
          v = 64'(IDCODE); len = 32;
        end else if (u >= 0) begin
          v = 64'(dr_cap_data[u*DR_W +: DR_W]); len = DR_W; m_stb[u] = 1'b1;
        end else begin
          v = '0; len = 1;
        end
        m_dr_ch = {};
        for (int i = 0; i < len; i++) m_dr_ch.push_back(v[i]);
      end
      SHIFT_DR: begin
        void'(m_dr_ch.pop_front());
        m_dr_ch.push_back(t_di);
      end
      UPD_DR: begin
        if (u >= 0) begin
          m_upd[u] = DR_W'(chain_val(m_dr_ch));
          m_vld[u] = 1'b1;
        end
      end
      default: ;
    endcase
    if (nx == TLR) m_ir = 1;
    m_state = nx;
  endtask

  function automatic logic exp_tdo();
    if (m_state == SHIFT_IR) return m_ir_ch[0];
    if (m_state == SHIFT_DR) return m_dr_ch[0];
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_upd();
    logic [63:0] e = '0;
    for (int k = 0; k < N_DR; k++) e[k*DR_W +: DR_W] = m_upd[k];
    return e;
  endfunction

  // ---------------- drivers ----------------
  // One tck cycle: drive, check tdo mid-cycle, take the edge, check registered outputs.
  task automatic step(input bit t_ms, input bit t_di, output logic tdo_s);
    tms = t_ms;
    tdi = t_di;
    #1;
    tdo_s = tdo;
    check("tdo", tdo, exp_tdo());
    check("tdo_en", tdo_en, (m_state == SHIFT_IR) || (m_state == SHIFT_DR));
    @(posedge tck);
    model_edge(t_ms, t_di);
    #1;
    stb_cnt += $countones(dr_cap_stb);
    vld_cnt += $countones(dr_upd_vld);
    check("tap_state", tap_state, m_state);
    check("ir_q", ir_q, m_ir);
    check("cap_stb", dr_cap_stb, m_stb);
    check("upd_vld", dr_upd_vld, m_vld);
    check("upd_data", dr_upd_data, exp_upd());
  endtask

  task automatic do_reset();
    trst = 1'b1;
    tms  = 1'b0;
    tdi  = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    model_reset();
    check("rst tap_state", tap_state, TLR);
    check("rst ir_q", ir_q, 1);
    check("rst tdo", {tdo, tdo_en}, 0);
    check("rst pulses", {dr_cap_stb, dr_upd_vld}, 0);
    check("rst upd_data", dr_upd_data, 0);
    trst = 1'b0;
  endtask

  // From RTI: DR scan of len bits, optional pause after bit pause_at, back to RTI.
  task automatic scan_dr(input logic [63:0] din, input int len, input int pause_at,
                         output logic [63:0] dout);
    logic b;
    dout = '0;
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < len; i++) begin
      step((i == len - 1) || (i == pause_at), din[i], b);
      dout[i] = b;
      if (i == pause_at && i != len - 1) begin
        step(0, 0, b); step(0, 0, b); step(1, 0, b); step(0, 0, b);
      end
    end
    step(1, 0, b); step(0, 0, b);
  endtask

  task automatic scan_ir(input logic [IR_W-1:0] din, output logic [IR_W-1:0] dout);
    logic b;
    dout = '0;
    step(1, 0, b); step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < IR_W; i++) begin
      step(i == IR_W - 1, din[i], b);
      dout[i] = b;
    end
    step(1, 0, b); step(0, 0, b);
  endtask

  typedef struct {
    logic [7:0] tms_bits;
    int         n;
    tap_state_t exp;
  } walk_vec_t;

  walk_vec_t   walks [$];
  logic [63:0] dout;
  logic [IR_W-1:0] irout;
  logic        b;

  initial begin
    trst = 1'b1; tms = 1'b0; tdi = 1'b0; dr_cap_data = '0;
    stb_cnt = 0; vld_cnt = 0;
    build_table();
    do_reset();

    // State walks from TLR, tms applied LSB first.
    walks = '{
      '{8'b0000000, 1, RTI},      '{8'b0000010, 2, SEL_DR},
      '{8'b0000010, 3, CAP_DR},   '{8'b0000010, 4, SHIFT_DR},
      '{8'b0001010, 4, EXIT1_DR}, '{8'b0001010, 5, PAUSE_DR},
      '{8'b0101010, 6, EXIT2_DR}, '{8'b0011010, 5, UPD_DR},
      '{8'b0000110, 3, SEL_IR},   '{8'b0000110, 4, CAP_IR},
      '{8'b0000110, 5, SHIFT_IR}, '{8'b0001110, 4, TLR},
      '{8'b0010110, 5, EXIT1_IR}, '{8'b0010110, 6, PAUSE_IR},
      '{8'b1010110, 7, EXIT2_IR}, '{8'b0110110, 6, UPD_IR},
      '{8'b1110110, 7, SEL_DR},   '{8'b0011010, 6, RTI},
      '{8'b0101010, 7, SHIFT_DR}, '{8'b0000001, 1, TLR}
    };
    foreach (walks[w]) begin
      do_reset();
      for (int i = 0; i < walks[w].n; i++) step(walks[w].tms_bits[i], 0, b);
      check($sformatf("walk %0d", w), tap_state, walks[w].exp);
    end

    // IDCODE readout.
    do_reset();
    step(0, 0, b);
    stb_cnt = 0; vld_cnt = 0;
    scan_dr('0, 32, -1, dout);
    check("idcode tdo", dout[31:0], 32'h1BA0_0477);
    check("idcode pulses", {stb_cnt[7:0], vld_cnt[7:0]}, 0);

    // IR write: capture pattern out, USER 0 in.
    scan_ir(4'h2, irout);
    check("ir capture", irout, 4'b0001);
    check("ir update", ir_q, 4'h2);

    // USER 0 straight scan, then the same through PAUSE_DR.
    dr_cap_data = {32'h0BAD_F00D, 32'h1234_5678};
    for (int p = 0; p < 2; p++) begin
      stb_cnt = 0; vld_cnt = 0;
      scan_dr(64'hDEAD_BEEF, 32, (p == 0) ? -1 : 13, dout);
      check($sformatf("user0 tdo p%0d", p), dout[31:0], 32'h1234_5678);
      check($sformatf("user0 upd p%0d", p), dr_upd_data[31:0], 32'hDEAD_BEEF);
      check($sformatf("user1 hold p%0d", p), dr_upd_data[63:32], 32'h0);
      check($sformatf("user0 pulses p%0d", p), {stb_cnt[7:0], vld_cnt[7:0]}, 16'h0101);
    end

    // Five tms=1 from SHIFT_DR reach TLR; update values survive.
    scan_ir(4'h1, irout);
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
    check("in shift_dr", tap_state, SHIFT_DR);
    repeat (5) step(1, 0, b);
    check("5 tms tlr", tap_state, TLR);
    check("5 tms ir", ir_q, 4'h1);
    check("5 tms upd kept", dr_upd_data[31:0], 32'hDEAD_BEEF);
    step(0, 0, b);

    // BYPASS: one-cycle delay, first bit 0.
    scan_ir(4'hF, irout);
    stb_cnt = 0; vld_cnt = 0;
    scan_dr(64'hA5, 8, -1, dout);
    check("bypass tdo", dout[7:0], 8'h4A);
    check("bypass pulses", {stb_cnt[7:0], vld_cnt[7:0]}, 0);

    // USER 1 write, then a scan aborted by trst after 10 bits.
    scan_ir(4'h3, irout);
    scan_dr(64'hCAFE_F00D, 32, -1, dout);
    check("user1 upd", dr_upd_data[63:32], 32'hCAFE_F00D);
    vld_cnt = 0;
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 1), b);
    trst = 1'b1;
    #1;
    model_reset();
    check("abort state", tap_state, TLR);
    check("abort ir", ir_q, 4'h1);
    check("abort upd", dr_upd_data, 0);
    check("abort tdo_en", tdo_en, 0);
    @(posedge tck);
    #1;
    trst = 1'b0;
    step(0, 0, b);
    check("abort vld", vld_cnt, 0);
    check("after abort rti", tap_state, RTI);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) dr_cap_data = {$urandom, $urandom};
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1), b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
